// File: rtl/reg_file_16x32.sv
// rtl/reg_file_16x32.sv - 16x32 register file, R15 is the PC with its own increment path.
// Optional write-through read bypass when REG_FILE_BYPASS_EN is defined.
module reg_file_16x32 #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   PC_STEP  = WIDTH'(4),
    parameter logic [WIDTH-1:0]   PC_RESET = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [3:0]       rw,
    input  logic [WIDTH-1:0] pw,
    input  logic             pc_inc,
    input  logic [3:0]       ra,
    input  logic [3:0]       rb,
    input  logic [3:0]       rd,
    output logic [WIDTH-1:0] pa,
    output logic [WIDTH-1:0] pb,
    output logic [WIDTH-1:0] pd,
    output logic [WIDTH-1:0] pc
);

    logic [WIDTH-1:0] regs [16];
    logic [15:0]      load_en;

    always_comb begin
        load_en = '0;
        if (we) begin
            load_en[rw] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= '0;
            end
            regs[15] <= PC_RESET;
        end else begin
            for (int i = 0; i < 15; i++) begin
                if (load_en[i]) begin
                    regs[i] <= pw;
                end
            end
            // An explicit write to R15 takes priority over the increment.
            if (load_en[15]) begin
                regs[15] <= pw;
            end else if (pc_inc) begin
                regs[15] <= regs[15] + PC_STEP;
            end
        end
    end

`ifdef REG_FILE_BYPASS_EN
    assign pa = (we && (ra == rw)) ? pw : regs[ra];
    assign pb = (we && (rb == rw)) ? pw : regs[rb];
    assign pd = (we && (rd == rw)) ? pw : regs[rd];
    assign pc = (we && (rw == 4'hF)) ? pw : regs[15];
`else
    assign pa = regs[ra];
    assign pb = regs[rb];
    assign pd = regs[rd];
    assign pc = regs[15];
`endif

endmodule

// File: tb/tb_reg_file_16x32.sv
// tb/tb_reg_file_16x32.sv - self-checking bench for reg_file_16x32.
module tb_reg_file_16x32;

    logic        clk = 1'b0;
    logic        reset, we, pc_inc;
    logic [3:0]  rw, ra, rb, rd;
    logic [31:0] pw, pa, pb, pd, pc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_regs [16];
    logic        model_valid = 1'b0;

    reg_file_16x32 dut (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .rw     (rw),
        .pw     (pw),
        .pc_inc (pc_inc),
        .ra     (ra),
        .rb     (rb),
        .rd     (rd),
        .pa     (pa),
        .pb     (pb),
        .pd     (pd),
        .pc     (pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: what each register must hold after every edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) model_regs[i] = 32'h0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (we) model_regs[rw] = pw;
            if (pc_inc && !(we && rw == 4'hF)) model_regs[15] = model_regs[15] + 32'd4;
        end
    end

    function automatic logic [31:0] exp_read(input logic [3:0] sel);
`ifdef REG_FILE_BYPASS_EN
        if (we && sel == rw) return pw;
`endif
        return model_regs[sel];
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            check("cmp_pa", pa, exp_read(ra));
            check("cmp_pb", pb, exp_read(rb));
            check("cmp_pd", pd, exp_read(rd));
            check("cmp_pc", pc, exp_read(4'hF));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; pc_inc = 1'b0;
        rw = 4'h0; pw = 32'h0; ra = 4'h0; rb = 4'h0; rd = 4'h0;
        tick();
        reset = 1'b0;

        // 1: reset then read
        for (int i = 0; i < 16; i++) begin
            ra = 4'(i);
            #2;
            check("reset_pa", pa, 32'h0);
            tick();
        end
        check("reset_pc", pc, 32'h0);

        // 2: write R0..R14, read back on all ports
        for (int n = 0; n < 15; n++) begin
            we = 1'b1; rw = 4'(n); pw = 32'(n);
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 15; i++) begin
            ra = 4'(i); rb = 4'(14 - i); rd = 4'(i);
            #2;
            check("wr_pa", pa, 32'(i));
            check("wr_pb", pb, 32'(14 - i));
            check("wr_pd", pd, 32'(i));
            tick();
        end
        we = 1'b1; rw = 4'h0; pw = 32'h00010000;
        tick();
        we = 1'b0; ra = 4'h0; rb = 4'h1;
        #1;
        check("r0_new", pa, 32'h00010000);
        check("r1_kept", pb, 32'h00000001);

        // 3: PC increment and wrap
        we = 1'b1; rw = 4'hF; pw = 32'hFFFFFFF8;
        tick();
        we = 1'b0; pc_inc = 1'b1;
        tick();
        check("pc_inc1", pc, 32'hFFFFFFFC);
        tick();
        check("pc_wrap", pc, 32'h00000000);
        tick();
        pc_inc = 1'b0;
        check("pc_inc3", pc, 32'h00000004);

        // 4: write/increment collision
        we = 1'b1; rw = 4'hF; pw = 32'h00000100;
        tick();
        check("pc_100", pc, 32'h00000100);
        pw = 32'h000000A0; pc_inc = 1'b1;
        tick();
        check("coll_pc", pc, 32'h000000A0);
        rw = 4'h7; pw = 32'h00000070;
        tick();
        we = 1'b0; pc_inc = 1'b0; ra = 4'h7;
        #1;
        check("coll_r7", pa, 32'h00000070);
        check("coll_pc2", pc, 32'h000000A4);

        // 5: same-cycle read of the register being written
        we = 1'b1; rw = 4'h7; pw = 32'h00000007;
        tick();
        ra = 4'h7; pw = 32'h00000070;
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("pre_edge", pa, 32'h00000070);
`else
        check("pre_edge", pa, 32'h00000007);
`endif
        tick();
        we = 1'b0;
        #1;
        check("post_edge", pa, 32'h00000070);

        // 6: reset overrides write and increment
        we = 1'b1; rw = 4'h3; pw = 32'h12345678;
        tick();
        reset = 1'b1; pw = 32'hDEADBEEF; pc_inc = 1'b1;
        tick();
        reset = 1'b0; we = 1'b0; pc_inc = 1'b0; ra = 4'h3; rb = 4'h7; rd = 4'hF;
        #1;
        check("rst_r3", pa, 32'h0);
        check("rst_r7", pb, 32'h0);
        check("rst_pc", pc, 32'h0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
